// File: rtl/qnn_dense_stream.sv
// Streaming quantised dense layer: loads one activation vector, then per output row
// accumulates LANES products per weight beat and emits a requantised int8 result.
module qnn_dense_stream #(
    parameter int IN_DIM  = 64,
    parameter int OUT_DIM = 16,
    parameter int LANES   = 4,
    parameter int ACC_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   cfg_prec,
    input  logic                         cfg_relu,
    input  logic [4:0]                   cfg_shift,
    input  logic [OUT_DIM*32-1:0]        bias,
    input  logic                         act_valid,
    output logic                         act_ready,
    input  logic [LANES*8-1:0]           act_data,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [LANES*8-1:0]           w_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_data,
    output logic [$clog2(OUT_DIM)-1:0]   out_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int B      = IN_DIM / LANES;
    localparam int BCNT_W = (B > 1) ? $clog2(B) : 1;
    localparam int IDX_W  = $clog2(OUT_DIM);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_ACT = 3'd1,
        MAC      = 3'd2,
        EMIT     = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [BCNT_W-1:0]         beat_q, beat_d;
    logic [IDX_W-1:0]          row_q, row_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [7:0]         out_data_q, out_data_d;
    logic [IDX_W-1:0]          out_idx_q, out_idx_d;
    logic [1:0]                prec_q, prec_d;
    logic                      relu_q, relu_d;
    logic [4:0]                shift_q, shift_d;
    logic [LANES*8-1:0]        act_buf_q [B];

    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   bias_row;

    // Precision-dependent lane decode; binary maps bit0 to +1/-1 so the plain
    // product already yields +1 on equal bits and -1 otherwise.
    function automatic logic signed [7:0] decode(input logic [7:0] b, input logic [1:0] prec);
        case (prec)
            2'd0:    decode = b;
            2'd1:    decode = {{4{b[3]}}, b[3:0]};
            default: decode = b[0] ? 8'sd1 : -8'sd1;
        endcase
    endfunction

    function automatic logic signed [ACC_W-1:0] lane_sum(input logic [LANES*8-1:0] a,
                                                          input logic [LANES*8-1:0] w,
                                                          input logic [1:0]         prec);
        logic signed [ACC_W-1:0] s;
        logic signed [15:0]      da;
        logic signed [15:0]      dw;
        logic signed [15:0]      p;
        s = '0;
        for (int l = 0; l < LANES; l++) begin
            da = 16'(decode(a[8*l +: 8], prec));
            dw = 16'(decode(w[8*l +: 8], prec));
            p  = da * dw;
            s  = s + ACC_W'(p);
        end
        return s;
    endfunction

    function automatic logic signed [7:0] requant(input logic signed [ACC_W-1:0] y,
                                                  input logic                    relu,
                                                  input logic [4:0]              sh);
        logic signed [ACC_W-1:0] r;
        r = (relu && (y < 0)) ? '0 : y;
        r = r >>> sh;
        if (r > 127)
            return 8'sd127;
        else if (r < -128)
            return -8'sd128;
        else
            return r[7:0];
    endfunction

    assign bias_row = ACC_W'($signed(bias[{row_q, 5'b0} +: 32]));
    assign acc_sum  = acc_q + lane_sum(act_buf_q[beat_q], w_data, prec_q);

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        row_d      = row_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        prec_d     = prec_q;
        relu_d     = relu_q;
        shift_d    = shift_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    prec_d  = cfg_prec;
                    relu_d  = cfg_relu;
                    shift_d = cfg_shift;
                    row_d   = '0;
                    beat_d  = '0;
                    state_d = LOAD_ACT;
                end
            end
            LOAD_ACT: begin
                if (act_valid) begin
                    if (beat_q == BCNT_W'(B - 1)) begin
                        beat_d  = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            MAC: begin
                if (w_valid) begin
                    acc_d = acc_sum;
                    if (beat_q == BCNT_W'(B - 1)) begin
                        // Result is registered on the row's last beat so EMIT presents it directly.
                        beat_d     = '0;
                        out_data_d = requant(acc_sum + bias_row, relu_q, shift_q);
                        out_idx_d  = row_q;
                        state_d    = EMIT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (row_q == IDX_W'(OUT_DIM - 1)) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        acc_d   = '0;
                        state_d = MAC;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            prec_q     <= '0;
            relu_q     <= 1'b0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            row_q      <= row_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            prec_q     <= prec_d;
            relu_q     <= relu_d;
            shift_q    <= shift_d;
        end
    end

    // Buffer contents need no reset: every run overwrites all B beats before MAC reads them.
    always_ff @(posedge clk) begin
        if (state_q == LOAD_ACT && act_valid)
            act_buf_q[beat_q] <= act_data;
    end

    assign act_ready = (state_q == LOAD_ACT);
    assign w_ready   = (state_q == MAC);
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

endmodule

// File: doc/qnn_dense_stream.md
# qnn_dense_stream

Streaming, parametrised quantised dense (fully connected) layer engine. Activations and weights arrive over valid/ready streams, and `LANES` multiply-accumulates run per cycle. Each output is bias-added, optionally passed through ReLU, requantised to int8 and streamed out. It sits between the activation buffer/DMA and the next layer, and supports INT8, INT4 and binary precision selected per run.

## Interface
- `IN_DIM`, 64: input vector length; must be a multiple of `LANES`.
- `OUT_DIM`, 16: number of output neurons.
- `LANES`, 4: elements consumed per beat; 8 bits per lane.
- `ACC_W`, 32: accumulator width.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin run; sampled only in IDLE.
- `cfg_prec`  in  2  0=INT8, 1=INT4, 2/3=BIN; latched at start.
- `cfg_relu`  in  1  enable ReLU; latched at start.
- `cfg_shift`  in  5  arithmetic right shift for requantisation; latched at start.
- `bias`  in  `OUT_DIM`*32  signed per-row bias; row o is at bits [32o+31:32o]; held stable during the run.
- `act_valid`/`act_ready`  in/out  1  activation stream handshake.
- `act_data`  in  `LANES`*8  lane l is at bits [8l+7:8l]; element index is beat*`LANES`+l.
- `w_valid`/`w_ready`  in/out  1  weight stream handshake; row-major order, `IN_DIM`/`LANES` beats per row.
- `w_data`  in  `LANES`*8  weight lanes, same packing as `act_data`.
- `out_valid`/`out_ready`  out/in  1  result handshake.
- `out_data`  out  8  signed int8 result.
- `out_idx`  out  $clog2(`OUT_DIM`)  row index of `out_data`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of run.

## Operation
- Let B = `IN_DIM`/`LANES`.
- FSM states: IDLE, LOAD_ACT, MAC, EMIT, DONE.
- IDLE:
  - on `start`, latch the cfg inputs, clear the row counter, go to LOAD_ACT.
  - `start` in any other state is ignored.
- LOAD_ACT:
  - `act_ready`=1.
  - each handshake writes `LANES` elements into the internal activation buffer.
  - after B beats, go to MAC with acc=0.
- MAC:
  - `w_ready`=1.
  - each handshake adds the sum of `LANES` lane products to acc.
  - cycles without a handshake leave acc unchanged.
  - after the row's B-th beat, go to EMIT.
- Lane decode:
  - INT8: the full byte, signed.
  - INT4: bits [3:0] sign-extended; bits [7:4] ignored.
  - BIN: bit 0 only, 0→−1 and 1→+1; product is +1 if the bits are equal, else −1.
- Accumulator: `ACC_W` bits, signed, wraps modulo 2^`ACC_W` with no saturation.
- EMIT, with y computed in `ACC_W` bits:
  - y = acc + bias[row].
  - if `cfg_relu` and y<0, y=0.
  - y = y >>> `cfg_shift`, i.e. floor rounding.
  - saturate y to [−128,127] and register it into `out_data`, with `out_idx`=row.
  - `out_valid`=1 until `out_ready`.
  - on the handshake: if row=`OUT_DIM`−1 go to DONE, else row++, acc=0, go to MAC.
- DONE: `done`=1 for this single cycle, then go to IDLE.
- Activations are not reused across runs; every run reloads them.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `act_ready`=0, `w_ready`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, acc=0.
- Reset is honoured in any state, including mid-run. It aborts the run and discards partial acc and buffer contents. No `out_valid` or `done` may follow the reset until a new `start`.
- `act_ready`, `w_ready` and `out_valid` are never high together. Each is a function of the registered state only, with no combinational path from valid to ready.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_idx` are held stable.
- Throughput with all valids and `out_ready` held high, start sampled at edge 0:
  - LOAD_ACT occupies cycles 1..B.
  - each row takes B+1 cycles (B MAC plus 1 EMIT).
  - `done` is high in cycle B+`OUT_DIM`·(B+1)+1. For the defaults this is cycle 289.
- Each stall cycle on a valid or on `out_ready` delays `done` by exactly one cycle.

## Test plan
- **INT8:** defaults, all act=1, all w=2, bias[0]=5, bias[1]=−100, other biases 0, shift=0, relu=0 → acc=128 per row; out row0=127 (saturated), row1=28, others 127; `done` in cycle 289.
- **INT4 garbage nibbles:** act bytes 0xAF (−1), w bytes 0x57 (7), bias 0, shift=2 → acc=−448; relu=0 gives −112 on every row; rerun with relu=1 gives 0.
- **BIN:** act bit0=1; row0 weights alternate 1/0 with bias 3 → 3; row1 all 1 with bias −10 → 54; row2 all 0, shift=0 → −64.
- **Backpressure and gaps:**
  - hold `out_ready`=0 for 5 cycles at row 0 → `out_data`/`out_idx` stable and `w_ready`=0 throughout;
  - deassert `w_valid` every other beat → results identical to the INT8 case;
  - `done` is delayed by the exact number of stall cycles.
- **Reset mid-MAC:** assert `rst_n`=0 for 1 cycle during row 3 → all outputs take their reset values. The next `start` with INT8 stimulus gives correct results, and no stale `out_valid` appears.
- **Start while busy:** pulse `start` during LOAD_ACT and during EMIT → ignored; exactly `OUT_DIM` outputs and one `done`. Changing `cfg_*` mid-run has no effect.
